warp_rr_scheduler: RTL and testbench

Round-robin warp arbiter that generates the `warp_select` index consumed by the per-warp state-holding warp controller. It tracks which launched warps are still runnable and rotates the shared core pipeline between them. Rotation happens only at safe points: a memory stall, quantum expiry at an instruction boundary, or warp completion. It inserts a one-cycle switch bubble so the outgoing warp's state is captured before the new warp's state is presented.

---
 rtl/warp_rr_scheduler.sv | 136 +++++++++++++
 tb/tb_warp_rr_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/warp_rr_scheduler.sv
// Round-robin warp arbiter: rotates the shared core pipeline between runnable warps
// at safe points (stall, quantum expiry, completion) with a one-cycle switch bubble.
module warp_rr_scheduler #(
    parameter int unsigned NUM_WARPS = 2,
    parameter int unsigned MAX_RUN   = 8,
    localparam int unsigned WSEL_W   = (NUM_WARPS > 2) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_WARPS-1:0] warp_start,
    input  logic [NUM_WARPS-1:0] warp_done,
    input  logic [2:0]           core_state,
    output logic [WSEL_W-1:0]    warp_select,
    output logic                 switch_stall,
    output logic                 switch_pulse,
    output logic                 all_done
);

    localparam int unsigned RCNT_RAW = $clog2(MAX_RUN) + 1;
    localparam int unsigned RCNT_W   = (RCNT_RAW < 3) ? 3 : RCNT_RAW;

    localparam logic [2:0] CS_WAIT   = 3'd4;
    localparam logic [2:0] CS_UPDATE = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_SWITCH = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [WSEL_W-1:0]   sel_nxt;
    logic [RCNT_W-1:0]   run_cnt, cnt_nxt;
    logic                pulse_nxt;

    logic [NUM_WARPS-1:0] elig;
    logic [NUM_WARPS-1:0] others;
    logic                 other_avail;
    logic [WSEL_W-1:0]    lowest;
    logic [WSEL_W-1:0]    next_rr;
    logic [WSEL_W-1:0]    rr_idx;
    logic                 rr_found;

    // Eligibility, lowest eligible index and round-robin successor of the current warp.
    // The successor search wraps back to the current warp only when it is the sole candidate.
    always_comb begin
        elig                = warp_start & ~warp_done;
        others              = elig;
        others[warp_select] = 1'b0;
        other_avail         = |others;

        lowest = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (elig[WSEL_W'(i)]) lowest = WSEL_W'(i);
        end

        next_rr  = warp_select;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int unsigned k = 1; k <= NUM_WARPS; k++) begin
            rr_idx = WSEL_W'((32'(warp_select) + k) % NUM_WARPS);
            if (!rr_found && elig[rr_idx]) begin
                next_rr  = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_nxt = state;
        sel_nxt   = warp_select;
        cnt_nxt   = run_cnt;
        pulse_nxt = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (|elig) begin
                    sel_nxt   = lowest;
                    cnt_nxt   = '0;
                    state_nxt = S_RUN;
                end else if (|warp_start) begin
                    state_nxt = S_DONE;
                end
            end
            S_RUN: begin
                // A dropped launch flag counts as completion of the selected warp.
                if (!elig[warp_select]) begin
                    state_nxt = other_avail ? S_SWITCH : S_DONE;
                end else if (core_state == CS_WAIT && other_avail) begin
                    state_nxt = S_SWITCH;
                end else if (core_state == CS_UPDATE) begin
                    if (run_cnt == RCNT_W'(MAX_RUN - 1)) begin
                        if (other_avail) state_nxt = S_SWITCH;
                        else             cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = run_cnt + RCNT_W'(1);
                    end
                end
            end
            S_SWITCH: begin
                if (!(|elig)) begin
                    state_nxt = S_DONE;
                end else begin
                    sel_nxt   = next_rr;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            warp_select  <= '0;
            run_cnt      <= '0;
            switch_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            warp_select  <= sel_nxt;
            run_cnt      <= cnt_nxt;
            switch_pulse <= pulse_nxt;
        end
    end

    assign switch_stall = (state == S_SWITCH);
    assign all_done     = (state == S_DONE);

endmodule

// File: tb/tb_warp_rr_scheduler.sv
// Bench for warp_rr_scheduler: directed scenarios with literal expectations plus
// randomized episodes checked every cycle against a behavioural model.
module tb_warp_rr_scheduler;

    localparam int NW      = 2;
    localparam int MR      = 8;
    localparam int WSEL_W  = 1;

    localparam logic [2:0] CS_FETCH  = 3'd1;
    localparam logic [2:0] CS_WAIT   = 3'd4;
    localparam logic [2:0] CS_UPDATE = 3'd6;

    // model phases
    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_SW   = 2;
    localparam int PH_DONE = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NW-1:0]     warp_start = '0;
    logic [NW-1:0]     warp_done = '0;
    logic [2:0]        core_state = 3'd0;
    logic [WSEL_W-1:0] warp_select;
    logic              switch_stall;
    logic              switch_pulse;
    logic              all_done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int m_phase = PH_IDLE;
    int m_sel   = 0;
    int m_used  = 0;
    int m_pulse = 0;

    warp_rr_scheduler #(.NUM_WARPS(NW), .MAX_RUN(MR)) dut (
        .clk          (clk),
        .reset        (reset),
        .warp_start   (warp_start),
        .warp_done    (warp_done),
        .core_state   (core_state),
        .warp_select  (warp_select),
        .switch_stall (switch_stall),
        .switch_pulse (switch_pulse),
        .all_done     (all_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit runnable(input int i);
        return warp_start[i] && !warp_done[i];
    endfunction

    // Behavioural model: advances once per posedge from the inputs applied in the previous cycle.
    always @(posedge clk) begin
        int  n_run;
        bit  rivals;
        int  cand;
        m_pulse = 0;
        if (reset) begin
            m_phase = PH_IDLE;
            m_sel   = 0;
            m_used  = 0;
        end else begin
            n_run  = 0;
            rivals = 0;
            for (int i = 0; i < NW; i++) begin
                if (runnable(i)) begin
                    n_run++;
                    if (i != m_sel) rivals = 1;
                end
            end
            if (m_phase == PH_IDLE) begin
                if (n_run > 0) begin
                    cand = -1;
                    for (int i = NW - 1; i >= 0; i--) if (runnable(i)) cand = i;
                    m_sel   = cand;
                    m_used  = 0;
                    m_phase = PH_RUN;
                end else if (warp_start != '0) begin
                    m_phase = PH_DONE;
                end
            end else if (m_phase == PH_RUN) begin
                if (!runnable(m_sel))                       m_phase = rivals ? PH_SW : PH_DONE;
                else if (core_state == CS_WAIT && rivals)   m_phase = PH_SW;
                else if (core_state == CS_UPDATE) begin
                    m_used++;
                    if (m_used == MR) begin
                        if (rivals) m_phase = PH_SW;
                        else        m_used  = 0;
                    end
                end
            end else if (m_phase == PH_SW) begin
                if (n_run == 0) begin
                    m_phase = PH_DONE;
                end else begin
                    for (int k = NW; k >= 1; k--)
                        if (runnable((m_sel + k) % NW)) cand = (m_sel + k) % NW;
                    m_sel   = cand;
                    m_used  = 0;
                    m_pulse = 1;
                    m_phase = PH_RUN;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model warp_select", int'(warp_select), m_sel);
            chk("model switch_stall", int'(switch_stall), int'(m_phase == PH_SW));
            chk("model switch_pulse", int'(switch_pulse), m_pulse);
            chk("model all_done", int'(all_done), int'(m_phase == PH_DONE));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit stall_seen;

        // reset / idle
        reset = 1'b1; warp_start = 2'b00; warp_done = 2'b00; core_state = CS_FETCH;
        cyc(2);
        chk_en = 1'b1;
        chk("rst warp_select", int'(warp_select), 0);
        chk("rst switch_stall", int'(switch_stall), 0);
        chk("rst switch_pulse", int'(switch_pulse), 0);
        chk("rst all_done", int'(all_done), 0);
        reset = 1'b0;
        cyc(2);
        chk("idle stays", int'(warp_select) + int'(all_done) + int'(switch_stall), 0);

        // start ordering and stall rotation
        warp_start = 2'b10;
        cyc(1);
        chk("start sel", int'(warp_select), 1);
        chk("start no pulse", int'(switch_pulse), 0);
        warp_start = 2'b11; core_state = CS_WAIT;
        cyc(1);
        chk("wait stall", int'(switch_stall), 1);
        chk("wait sel held", int'(warp_select), 1);
        core_state = CS_FETCH;
        cyc(1);
        chk("wait new sel", int'(warp_select), 0);
        chk("wait pulse", int'(switch_pulse), 1);
        chk("wait stall off", int'(switch_stall), 0);

        // quantum expiry on warp 0 then warp 1
        core_state = CS_UPDATE;
        cyc(7);
        chk("quantum early", int'(switch_stall), 0);
        cyc(1);
        chk("quantum stall", int'(switch_stall), 1);
        core_state = CS_FETCH;
        cyc(1);
        chk("quantum sel1", int'(warp_select), 1);
        core_state = CS_UPDATE;
        cyc(8);
        chk("quantum stall2", int'(switch_stall), 1);
        core_state = CS_FETCH;
        cyc(1);
        chk("quantum sel0", int'(warp_select), 0);
        chk("quantum pulse", int'(switch_pulse), 1);

        // completion
        warp_done = 2'b01;
        cyc(1);
        chk("done stall", int'(switch_stall), 1);
        cyc(1);
        chk("done sel1", int'(warp_select), 1);
        warp_done = 2'b11;
        cyc(1);
        chk("all_done", int'(all_done), 1);
        cyc(3);
        chk("all_done held", int'(all_done), 1);

        // reset during the switch bubble
        reset = 1'b1; warp_done = 2'b00; warp_start = 2'b11; core_state = CS_FETCH;
        cyc(1);
        reset = 1'b0;
        cyc(1);
        core_state = CS_WAIT;
        cyc(1);
        chk("rsw stall", int'(switch_stall), 1);
        reset = 1'b1; core_state = CS_FETCH;
        cyc(1);
        chk("rsw no pulse", int'(switch_pulse), 0);
        chk("rsw sel", int'(warp_select), 0);
        chk("rsw stall off", int'(switch_stall), 0);
        reset = 1'b0;

        // simultaneous done and WAIT: never returns to the finished warp
        cyc(1);
        warp_done = 2'b01; core_state = CS_WAIT;
        cyc(2);
        chk("dw sel1", int'(warp_select), 1);
        cyc(5);
        chk("dw stays", int'(warp_select), 1);
        chk("dw no stall", int'(switch_stall), 0);

        // single warp: WAITs and 20 UPDATEs never rotate
        reset = 1'b1; warp_start = 2'b01; warp_done = 2'b00; core_state = CS_FETCH;
        cyc(1);
        reset = 1'b0;
        stall_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            core_state = (i % 2 == 0) ? CS_WAIT : CS_UPDATE;
            cyc(1);
            if (switch_stall) stall_seen = 1'b1;
        end
        chk("single sel", int'(warp_select), 0);
        chk("single no stall", int'(stall_seen), 0);

        // randomized episodes
        for (int ep = 0; ep < 20; ep++) begin
            reset = 1'b1; warp_done = '0;
            warp_start = NW'($urandom_range(1, (1 << NW) - 1));
            core_state = CS_FETCH;
            cyc(1);
            reset = 1'b0;
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 2) == 0) core_state = CS_UPDATE;
                else                           core_state = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 39) == 0) warp_done[$urandom_range(0, NW - 1)] = 1'b1;
                if ($urandom_range(0, 59) == 0) warp_start[$urandom_range(0, NW - 1)] ^= 1'b1;
                cyc(1);
            end
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
